// File: rtl/sdram_wb_prefetch.sv
// sdram_wb_prefetch: Wishbone front end for sdram_controller.
// Reads in the burst window pull a whole aligned line into a local buffer so
// later reads of that line ack in one cycle; writes go straight through to
// the controller and patch the buffered copy when they land in that line.
module sdram_wb_prefetch #(
    parameter int          DEPTH      = 8,
    parameter logic [23:0] BURST_BASE = 24'h380002
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        pf_flush,
    output logic [22:0] ctrl_addr,
    output logic        ctrl_rw,
    output logic [31:0] ctrl_data_in,
    output logic [3:0]  ctrl_mask,
    output logic        ctrl_in_valid,
    input  logic        ctrl_busy,
    input  logic [31:0] ctrl_data_out,
    input  logic        ctrl_out_valid
);
    localparam int L     = $clog2(DEPTH);
    localparam int TAG_W = 21 - L;

    typedef enum logic [2:0] {IDLE, WR, RD, FILL_REQ, FILL_WAIT, ACK} state_t;

    state_t           state;
    logic             line_valid;
    logic             flush_pend;
    logic             issued;
    logic             abort_q;
    logic [TAG_W-1:0] tag_q;
    logic [L-1:0]     k;
    logic [L-1:0]     req_idx;
    logic [31:0]      line_buf [DEPTH];

    logic             req;
    logic             in_win;
    logic             hit;
    logic             live;
    logic             in_fill;
    logic             wr_go;
    logic             wr_hit;
    logic [TAG_W-1:0] tag_in;
    logic [L-1:0]     idx_in;
    logic [L-1:0]     k_next;
    logic             unused_adr;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

    assign req        = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign in_win     = (wbs_adr_i[31:8] == BURST_BASE);
    assign tag_in     = wbs_adr_i[22:L+2];
    assign idx_in     = wbs_adr_i[L+1:2];
    // A flush in the same cycle as the request wins, so the read misses.
    assign hit        = line_valid & ~pf_flush & (tag_in == tag_q);
    // Requester still present and has not dropped out earlier in this transaction.
    assign live       = wbs_stb_i & wbs_cyc_i & ~abort_q;
    assign in_fill    = (state == FILL_REQ) | (state == FILL_WAIT);
    assign k_next     = k + L'(1);
    assign wr_go      = (state == WR) & live & ~ctrl_busy;
    // Tag comparison uses the SDRAM address, so any alias of the line stays coherent.
    assign wr_hit     = line_valid & (ctrl_addr[22:L+2] == tag_q);
    assign unused_adr = ^wbs_adr_i[1:0];

    // Command strobe is gated by busy so it can only fire in an accepting cycle.
    assign ctrl_in_valid = ~ctrl_busy & (((state == WR) & live) |
                                         ((state == RD) & ~issued & live) |
                                         (state == FILL_REQ));

    // Main control FSM: dispatch Wishbone requests and sequence controller commands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            line_valid   <= 1'b0;
            flush_pend   <= 1'b0;
            issued       <= 1'b0;
            abort_q      <= 1'b0;
            tag_q        <= '0;
            k            <= '0;
            req_idx      <= '0;
            wbs_ack_o    <= 1'b0;
            wbs_dat_o    <= '0;
            ctrl_addr    <= '0;
            ctrl_rw      <= 1'b0;
            ctrl_data_in <= '0;
            ctrl_mask    <= '0;
        end else begin
            wbs_ack_o <= 1'b0;
            if (pf_flush) begin
                if (in_fill) flush_pend <= 1'b1;
                else         line_valid <= 1'b0;
            end
            if (state != IDLE && state != ACK && !(wbs_stb_i && wbs_cyc_i))
                abort_q <= 1'b1;
            case (state)
                IDLE: begin
                    abort_q <= 1'b0;
                    issued  <= 1'b0;
                    if (req) begin
                        ctrl_addr <= wbs_adr_i[22:0];
                        req_idx   <= idx_in;
                        if (wbs_we_i) begin
                            ctrl_rw      <= 1'b1;
                            ctrl_data_in <= wbs_dat_i;
                            ctrl_mask    <= wbs_sel_i;
                            state        <= WR;
                        end else begin
                            ctrl_rw      <= 1'b0;
                            ctrl_data_in <= '0;
                            ctrl_mask    <= 4'b0000;
                            if (in_win && hit) begin
                                wbs_dat_o <= line_buf[idx_in];
                                wbs_ack_o <= 1'b1;
                                state     <= ACK;
                            end else if (in_win) begin
                                k          <= '0;
                                line_valid <= 1'b0;
                                flush_pend <= 1'b0;
                                tag_q      <= tag_in;
                                ctrl_addr  <= {tag_in, {L{1'b0}}, 2'b00};
                                state      <= FILL_REQ;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end
                WR: begin
                    if (!live) begin
                        state <= IDLE;
                    end else if (!ctrl_busy) begin
                        wbs_ack_o <= 1'b1;
                        state     <= ACK;
                    end
                end
                RD: begin
                    if (!issued) begin
                        if (!live)           state  <= IDLE;
                        else if (!ctrl_busy) issued <= 1'b1;
                    end else if (ctrl_out_valid) begin
                        issued <= 1'b0;
                        if (live) begin
                            wbs_dat_o <= ctrl_data_out;
                            wbs_ack_o <= 1'b1;
                            state     <= ACK;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                FILL_REQ: begin
                    if (!ctrl_busy) state <= FILL_WAIT;
                end
                FILL_WAIT: begin
                    if (ctrl_out_valid) begin
                        if (k != L'(DEPTH - 1)) begin
                            k         <= k_next;
                            ctrl_addr <= {tag_q, k_next, 2'b00};
                            state     <= FILL_REQ;
                        end else begin
                            k          <= '0;
                            line_valid <= ~(flush_pend | pf_flush);
                            flush_pend <= 1'b0;
                            if (live) begin
                                wbs_dat_o <= (req_idx == k) ? ctrl_data_out : line_buf[req_idx];
                                wbs_ack_o <= 1'b1;
                                state     <= ACK;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Line buffer storage: filled from the controller, patched by write-through hits.
    always_ff @(posedge clk) begin
        if (state == FILL_WAIT && ctrl_out_valid)
            line_buf[k] <= ctrl_data_out;
        else if (wr_go && wr_hit)
            line_buf[ctrl_addr[L+1:2]] <= merge_bytes(line_buf[ctrl_addr[L+1:2]], ctrl_data_in, ctrl_mask);
    end

endmodule

// File: tb/tb_sdram_wb_prefetch.sv
// Directed bench for sdram_wb_prefetch with a small SDRAM controller model
// (fixed read latency, honours busy) and a scoreboard of expected read data.
module tb_sdram_wb_prefetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        pf_flush;
    logic [22:0] ctrl_addr;
    logic        ctrl_rw;
    logic [31:0] ctrl_data_in;
    logic [3:0]  ctrl_mask;
    logic        ctrl_in_valid;
    logic        ctrl_busy;
    logic [31:0] ctrl_data_out;
    logic        ctrl_out_valid;

    always #5 clk = ~clk;

    sdram_wb_prefetch #(.DEPTH(8), .BURST_BASE(24'h380002)) dut (
        .clk(clk), .rst(rst),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o), .pf_flush(pf_flush),
        .ctrl_addr(ctrl_addr), .ctrl_rw(ctrl_rw), .ctrl_data_in(ctrl_data_in),
        .ctrl_mask(ctrl_mask), .ctrl_in_valid(ctrl_in_valid), .ctrl_busy(ctrl_busy),
        .ctrl_data_out(ctrl_data_out), .ctrl_out_valid(ctrl_out_valid)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sd_mem  [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_q [$];
    int          ncmd = 0, pcyc = 0, ov_cyc = 0, busy_viol = 0, n_ack = 0, resp_cnt = 0;
    logic [31:0] resp_data;
    logic [22:0] cmd_addr [0:1023];
    logic        last_rw;
    logic [3:0]  last_mask;
    logic [31:0] last_data;

    function automatic logic [31:0] apply_sel(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] sel);
        logic [31:0] m;
        m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        return (old_w & ~m) | (new_w & m);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // SDRAM controller model: logs commands, applies writes, returns reads 2 cycles later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_out_valid <= 1'b0;
            ctrl_data_out  <= '0;
            resp_cnt = 0;
        end else begin
            pcyc++;
            ctrl_out_valid <= 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    ctrl_out_valid <= 1'b1;
                    ctrl_data_out  <= resp_data;
                    ov_cyc = pcyc;
                end
            end
            if (ctrl_in_valid) begin
                if (ctrl_busy) busy_viol++;
                if (ncmd < 1024) cmd_addr[ncmd] = ctrl_addr;
                ncmd++;
                last_rw   = ctrl_rw;
                last_mask = ctrl_mask;
                last_data = ctrl_data_in;
                if (ctrl_rw) begin
                    sd_mem[ctrl_addr[9:2]] = apply_sel(sd_mem[ctrl_addr[9:2]], ctrl_data_in, ctrl_mask);
                end else begin
                    resp_data = sd_mem[ctrl_addr[9:2]];
                    resp_cnt  = 2;
                end
            end
        end
    end

    // Ack counter for transactions driven outside the read/write tasks.
    always @(negedge clk) begin
        if (wbs_ack_o) n_ack++;
    end

    task automatic wb_read(input logic [31:0] addr, input bit flush_too,
                           output int lat, output int ncmds, output int ov_gap);
        int          s;
        bit          got;
        logic [31:0] e;
        exp_q.push_back(ref_mem[addr[9:2]]);
        s = ncmd;
        @(negedge clk);
        wbs_adr_i = addr; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        if (flush_too) pf_flush = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (flush_too && i == 0) pf_flush = 1'b0;
            lat++;
            if (wbs_ack_o) got = 1'b1;
        end
        ov_gap = pcyc - ov_cyc;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        check("rd_ack_seen", {31'd0, got}, 32'd1);
        e = exp_q.pop_front();
        if (got) check("rd_data", wbs_dat_o, e);
        ncmds = ncmd - s;
    endtask

    task automatic wb_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel,
                            output int lat, output int ncmds);
        int s;
        bit got;
        s = ncmd;
        ref_mem[addr[9:2]] = apply_sel(ref_mem[addr[9:2]], data, sel);
        @(negedge clk);
        wbs_adr_i = addr; wbs_we_i = 1'b1; wbs_sel_i = sel; wbs_dat_i = data;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (wbs_ack_o) got = 1'b1;
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        check("wr_ack_seen", {31'd0, got}, 32'd1);
        ncmds = ncmd - s;
    endtask

    task automatic flush_pulse();
        @(negedge clk);
        pf_flush = 1'b1;
        @(negedge clk);
        pf_flush = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nc, gap, s, s2, a0;
        for (int i = 0; i < 256; i++) begin
            sd_mem[i]  = 32'hD000_0000 | i;
            ref_mem[i] = 32'hD000_0000 | i;
        end
        for (int n = 0; n < 8; n++) begin
            sd_mem[8'h80 + n]  = 32'hA0 + n;
            ref_mem[8'h80 + n] = 32'hA0 + n;
        end
        rst = 1'b1;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = '0; wbs_dat_i = '0;
        pf_flush = 1'b0; ctrl_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        check("rst_dat_o", wbs_dat_o, 32'd0);
        check("rst_in_valid", {31'd0, ctrl_in_valid}, 32'd0);
        check("rst_addr", {9'd0, ctrl_addr}, 32'd0);
        check("rst_mask_rw", {27'd0, ctrl_rw, ctrl_mask}, 32'd0);
        rst = 1'b0;

        // Miss fetches the whole line, then a hit in that line.
        wb_read(32'h3800_0208, 1'b0, lat, nc, gap);
        check("miss_cmds", nc, 8);
        check("miss_ack_gap", gap, 1);
        for (int i = 0; i < 8; i++) check("miss_addr", {9'd0, cmd_addr[ncmd - 8 + i]}, 32'h200 + 4 * i);
        wb_read(32'h3800_0214, 1'b0, lat, nc, gap);
        check("hit_lat", lat, 1);
        check("hit_cmds", nc, 0);

        // Write-through with partial byte lanes, then hit on the merged word.
        wb_write(32'h3800_0200, 32'h1122_3344, 4'b0011, lat, nc);
        check("wr_cmds", nc, 1);
        check("wr_lat", lat, 2);
        check("wr_rw", {31'd0, last_rw}, 32'd1);
        check("wr_mask", {28'd0, last_mask}, 32'h3);
        check("wr_addr", {9'd0, cmd_addr[ncmd - 1]}, 32'h200);
        check("wr_data", last_data, 32'h1122_3344);
        wb_read(32'h3800_0200, 1'b0, lat, nc, gap);
        check("merge_hit_lat", lat, 1);
        check("merge_hit_cmds", nc, 0);

        // Out-of-window read goes straight to the controller; line stays valid.
        wb_read(32'h3800_0010, 1'b0, lat, nc, gap);
        check("rd_cmds", nc, 1);
        check("rd_ack_gap", gap, 1);
        check("rd_addr", {9'd0, cmd_addr[ncmd - 1]}, 32'h10);
        wb_read(32'h3800_021C, 1'b0, lat, nc, gap);
        check("post_rd_hit_lat", lat, 1);
        check("post_rd_hit_cmds", nc, 0);

        // Flush during a fill: request still served, line left invalid.
        flush_pulse();
        s = ncmd;
        fork
            wb_read(32'h3800_0204, 1'b0, lat, nc, gap);
            begin
                for (int i = 0; i < 400 && ncmd < s + 6; i++) @(negedge clk);
                pf_flush = 1'b1;
                @(negedge clk);
                pf_flush = 1'b0;
            end
        join
        check("flushfill_cmds", nc, 8);
        check("flushfill_ack_gap", gap, 1);
        wb_read(32'h3800_0218, 1'b0, lat, nc, gap);
        check("after_flush_cmds", nc, 8);

        // Reset in the middle of a fill.
        flush_pulse();
        s = ncmd;
        @(negedge clk);
        wbs_adr_i = 32'h3800_0204; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        for (int i = 0; i < 400 && ncmd < s + 4; i++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_ack", {31'd0, wbs_ack_o}, 32'd0);
        check("midrst_in_valid", {31'd0, ctrl_in_valid}, 32'd0);
        check("midrst_addr", {9'd0, ctrl_addr}, 32'd0);
        check("midrst_dat_o", wbs_dat_o, 32'd0);
        check("midrst_data_in", ctrl_data_in, 32'd0);
        s2 = ncmd;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_no_cmd", ncmd - s2, 0);
        rst = 1'b0;
        wb_read(32'h3800_0204, 1'b0, lat, nc, gap);
        check("refetch_cmds", nc, 8);

        // Abort under controller back-pressure: fill completes, no ack, line valid.
        flush_pulse();
        @(negedge clk);
        #1 a0 = n_ack;
        s = ncmd;
        ctrl_busy = 1'b1;
        wbs_adr_i = 32'h3800_020C; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        repeat (10) @(negedge clk);
        check("busy_no_cmd", ncmd - s, 0);
        ctrl_busy = 1'b0;
        for (int i = 0; i < 400 && ncmd < s + 3; i++) @(negedge clk);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        for (int i = 0; i < 400 && ncmd < s + 8; i++) @(negedge clk);
        repeat (8) @(negedge clk);
        #1;
        check("abort_cmds", ncmd - s, 8);
        check("abort_no_ack", n_ack - a0, 0);
        wb_read(32'h3800_0214, 1'b0, lat, nc, gap);
        check("abort_line_hit_lat", lat, 1);
        check("abort_line_hit_cmds", nc, 0);

        // Flush in the same cycle as the request forces a miss.
        wb_read(32'h3800_0208, 1'b1, lat, nc, gap);
        check("same_cycle_flush_cmds", nc, 8);

        check("busy_violations", busy_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sdram_wb_prefetch.md
# sdram_wb_prefetch

Wishbone-side front end for the user-area SDRAM controller. Sits between the Wishbone slave port (WB MI A) and `sdram_controller`, converting Wishbone cycles into single-command controller transactions. Reads that hit the burst window (`wbs_adr_i[31:8] == BURST_BASE`) fetch a whole aligned line of DEPTH words into a local line buffer, so later reads from that line complete in one cycle. Writes are write-through and keep the buffered line coherent.

## Interface
Parameters:
- `DEPTH`, 8: words per prefetch line; a power of 2, from 2 to 32.
- `BURST_BASE`, 24'h380002: value of `wbs_adr_i[31:8]` that selects the prefetch path.

Ports:
- `clk`  in  1  single clock, shared with the controller.
- `rst`  in  1  reset; asynchronous, active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone strobe, cycle and write-enable.
- `wbs_sel_i`  in  4  byte lanes.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  one-cycle acknowledge; registered.
- `wbs_dat_o`  out  32  read data; registered, valid while `wbs_ack_o` is high.
- `pf_flush`  in  1  invalidates the line buffer.
- `ctrl_addr`  out  23  controller byte address.
- `ctrl_rw`  out  1  1 = write, 0 = read.
- `ctrl_data_in`  out  32  write data to the controller.
- `ctrl_mask`  out  4  byte mask; `wbs_sel_i` on writes, 4'b0000 on reads.
- `ctrl_in_valid`  out  1  command strobe.
- `ctrl_busy`  in  1  controller cannot accept a command.
- `ctrl_data_out`  in  32  read data from the controller.
- `ctrl_out_valid`  in  1  one-cycle pulse marking `ctrl_data_out` valid.

## Operation
- Request = `wbs_stb_i & wbs_cyc_i & ~wbs_ack_o`. It is sampled only in IDLE.
- Line geometry:
  - L = log2(DEPTH).
  - Word index = `wbs_adr_i[L+1:2]`.
  - Tag = `wbs_adr_i[22:L+2]`.
  - Line base = `{tag, L+2 zero bits}`.
- State = `{line_valid, tag_q, buf[DEPTH]}`.
- States: IDLE, WR, RD, FILL_REQ, FILL_WAIT, ACK.
- IDLE dispatch, highest priority first:
  1. Write → WR.
  2. Read, in window, `line_valid` set and tag equal (hit) → load `wbs_dat_o` from `buf[index]`, then ACK.
  3. Read, in window, miss → `k=0`, `line_valid=0`, latch tag, then FILL_REQ.
  4. Read, outside window → RD.
- WR: once `ctrl_busy=0`, issue the command (`rw=1`, address, data, mask), then ACK. If `line_valid` is set and the tag matches, merge `wbs_dat_i` into `buf[index]` per `wbs_sel_i`.
- RD: issue a read, wait for `ctrl_out_valid`, load `wbs_dat_o` from `ctrl_data_out`, then ACK.
- FILL_REQ: once `ctrl_busy=0`, issue a read at `line base + 4k`, then FILL_WAIT.
- FILL_WAIT: on `ctrl_out_valid`:
  - Store `buf[k] = ctrl_data_out`.
  - If `k < DEPTH-1`: increment `k`, go to FILL_REQ.
  - Otherwise: set `line_valid`, load `wbs_dat_o` from the requested word, go to ACK.
- ACK: drive `wbs_ack_o=1` for one cycle, then IDLE.
- Abort: if `wbs_cyc_i` or `wbs_stb_i` falls before ACK, any in-flight controller read still completes. A fill still runs to the end and sets `line_valid`. The ack is suppressed: go straight to IDLE.
- `pf_flush`:
  - Outside FILL: clears `line_valid` next cycle.
  - During FILL: sets a sticky `flush_pend`, so `line_valid` stays 0 when the fill ends. The current request is still served from the fill.
- `ctrl_out_valid` outside RD/FILL_WAIT is ignored.

## Timing
- Reset (asynchronous) clears, regardless of state: all outputs = 0, state = IDLE, `line_valid=0`, `k=0`, `flush_pend=0`, `buf` contents don't-care.
- `ctrl_in_valid` is a single-cycle pulse, asserted only in a cycle with `ctrl_busy=0`. The command is accepted in that cycle. `ctrl_addr`, `ctrl_rw`, `ctrl_data_in` and `ctrl_mask` are stable in that cycle.
- Hit: request sampled in cycle 0 → `wbs_ack_o` in cycle 1.
- Write: request in cycle 0 → `ctrl_in_valid` in the first cycle ≥1 with `ctrl_busy=0` → ack in the next cycle.
- RD: ack 1 cycle after `ctrl_out_valid`.
- Miss: exactly DEPTH commands, issued at strictly ascending addresses with no gaps in order. Ack 1 cycle after the last `ctrl_out_valid`.
- Back-to-back: IDLE is entered the cycle after the ack, and a new request may be sampled there. A still-high `stb` is not re-counted during the ack cycle.
- Request and `pf_flush` in the same IDLE cycle: the flush applies first, so a read is treated as a miss.

## Test plan
- Reset mid-fill:
  - Stimulus: assert `rst` at `k=3`.
  - Response: all outputs 0 immediately, no further `ctrl_in_valid`, `line_valid=0`.
  - Then: a read of 0x38000204 refetches the whole line.
- Miss then hit:
  - Stimulus: SDRAM word n preloaded with 0xA0+n; read 0x38000208.
  - Response: 8 commands at 0x200..0x21C; ack with 0xA2.
  - Then: a read of 0x38000214 acks in 1 cycle with 0xA5 and issues no controller command.
- Write-through merge:
  - Stimulus: with the line valid, write 0x11223344 with sel=4'b0011 to 0x38000200; then read the same address.
  - Response: the write issues one controller command with mask 4'b0011; the read is a hit returning `{orig[31:16], 16'h3344}`.
- Out-of-window read:
  - Stimulus: read 0x38000010.
  - Response: exactly one controller read; ack 1 cycle after `ctrl_out_valid`; `line_valid` unchanged.
- Flush during fill:
  - Stimulus: pulse `pf_flush` at `k=5`.
  - Response: the fill completes and the requester gets its ack.
  - Then: the next read of the same line misses and issues 8 commands.
- Abort with controller back-pressure:
  - Stimulus: hold `ctrl_busy` high for 10 cycles; drop `wbs_cyc_i` mid-fill.
  - Response: no `ctrl_in_valid` while busy; the fill finishes; no ack; the line is valid.
